// File: rtl/bpu_update_sched_pkg.sv
`default_nettype none
// ============================================================================
// bpu_update_sched_pkg : shared BPU types (update entry, scheduler FSM, sizes)
// Revision: 1.0
// ============================================================================
package bpu_update_sched_pkg;

   localparam int BPU_ADDR_W    = 64;
   localparam int BPU_SET_COUNT = 64;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } bpu_state_e;

   typedef struct packed {
      logic                  cond;
      logic                  taken;
      logic [1:0]            way;
      logic [BPU_ADDR_W-1:0] pc;
      logic [BPU_ADDR_W-1:0] target;
   } bpu_upd_t;

endpackage
`default_nettype wire

// File: rtl/bpu_update_sched_if.sv
`default_nettype none
// ============================================================================
// bpu_update_sched_if : execute-to-scheduler offer bus and predictor update bus
// Revision: 1.0
// ============================================================================
interface bpu_update_sched_if
   import bpu_update_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = BPU_ADDR_W
);
   logic                  i_upd_valid;
   logic                  i_upd_cond;
   logic                  i_upd_taken;
   logic [1:0]            i_upd_way;
   logic [ADDR_WIDTH-1:0] i_upd_pc;
   logic [ADDR_WIDTH-1:0] i_upd_target;
   logic                  o_upd_ready;

   logic                  o_bp_branch_instr;
   logic                  o_bp_branch_taken;
   logic [1:0]            o_bp_way;
   logic [ADDR_WIDTH-1:0] o_bp_pc_exec;
   logic [ADDR_WIDTH-1:0] o_bp_target;

   modport master (
      output i_upd_valid, i_upd_cond, i_upd_taken, i_upd_way, i_upd_pc, i_upd_target,
      input  o_upd_ready,
      input  o_bp_branch_instr, o_bp_branch_taken, o_bp_way, o_bp_pc_exec, o_bp_target
   );

   modport slave (
      input  i_upd_valid, i_upd_cond, i_upd_taken, i_upd_way, i_upd_pc, i_upd_target,
      output o_upd_ready,
      output o_bp_branch_instr, o_bp_branch_taken, o_bp_way, o_bp_pc_exec, o_bp_target
   );
endinterface
`default_nettype wire

// File: rtl/bpu_upd_fifo.sv
`default_nettype none
// ============================================================================
// bpu_upd_fifo : small power-of-two FIFO for pending predictor updates
// Revision: 1.0
// ============================================================================
module bpu_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  wire logic                       clk_i,
   input  wire logic                       arst_ni,
   input  wire logic                       flush_i,
   input  wire logic                       push_i,
   input  wire logic [WIDTH-1:0]           data_i,
   input  wire logic                       pop_i,
   output      logic [WIDTH-1:0]           data_o,
   output      logic                       full_o,
   output      logic [$clog2(DEPTH):0]     count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push_i && (count_q != CNT_FULL);
   assign w_do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap naturally because DEPTH is a power of two.
         if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_FULL);
   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bpu_update_sched.sv
`default_nettype none
// ============================================================================
// bpu_update_sched : replays resolved-branch updates into the BTB/BHT and
//                    sweeps every predictor set clear after reset or request
// Revision: 1.0
// ============================================================================
module bpu_update_sched
   import bpu_update_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = BPU_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int SET_COUNT  = BPU_SET_COUNT
) (
   input  wire logic                         i_clk,
   input  wire logic                         i_arst,
   input  wire logic                         i_stall_fetch,
   input  wire logic                         i_init_req,
   bpu_update_sched_if.slave                 bus,
   output      logic                         o_init_valid,
   output      logic [$clog2(SET_COUNT)-1:0] o_init_index,
   output      logic                         o_fetch_hold,
   output      logic [7:0]                   o_drop_cnt
);
   localparam int IDX_W = $clog2(SET_COUNT);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SET_COUNT - 1);

   bpu_state_e            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [7:0]            drop_q, drop_d;
   logic                  bp_instr_q;
   logic                  bp_taken_q;
   logic [1:0]            bp_way_q;
   logic [ADDR_WIDTH-1:0] bp_pc_q;
   logic [ADDR_WIDTH-1:0] bp_target_q;

   logic                  w_run;
   logic                  w_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic [CNT_W-1:0]      w_count;
   bpu_upd_t              w_in;
   bpu_upd_t              w_head;

   assign w_run   = (state_q == RUN);
   // Ready comes only from registered state, never from this cycle's pop.
   assign w_ready = w_run && !w_full;
   assign w_push  = bus.i_upd_valid && w_ready && !i_init_req;
   assign w_pop   = w_run && (w_count != '0) && !i_stall_fetch && !i_init_req;

   always_comb begin
      w_in        = '0;
      w_in.cond   = bus.i_upd_cond;
      w_in.taken  = bus.i_upd_taken;
      w_in.way    = bus.i_upd_way;
      w_in.pc     = bus.i_upd_pc;
      w_in.target = bus.i_upd_target;
   end

   bpu_upd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(bpu_upd_t))
   ) u_fifo (
      .clk_i   (i_clk),
      .arst_ni (i_arst),
      .flush_i (i_init_req),
      .push_i  (w_push),
      .data_i  (w_in),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .count_o (w_count)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
      if (i_init_req) begin
         state_d = INIT;
         idx_d   = '0;
      end else if (state_q == INIT) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == IDX_LAST) state_d = RUN;
      end
      // Any offer that is not accepted, including one racing an init request, is lost.
      if (bus.i_upd_valid && !w_push && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge i_clk or negedge i_arst) begin
      if (!i_arst) begin
         state_q     <= INIT;
         idx_q       <= '0;
         drop_q      <= '0;
         bp_instr_q  <= 1'b0;
         bp_taken_q  <= 1'b0;
         bp_way_q    <= '0;
         bp_pc_q     <= '0;
         bp_target_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         drop_q     <= drop_d;
         bp_instr_q <= w_pop && (w_head.cond || w_head.taken);
         if (w_pop) begin
            bp_taken_q  <= w_head.taken;
            bp_way_q    <= w_head.way;
            bp_pc_q     <= w_head.pc;
            bp_target_q <= w_head.target;
         end
      end
   end

   assign bus.o_upd_ready       = w_ready;
   assign bus.o_bp_branch_instr = bp_instr_q;
   assign bus.o_bp_branch_taken = bp_taken_q;
   assign bus.o_bp_way          = bp_way_q;
   assign bus.o_bp_pc_exec      = bp_pc_q;
   assign bus.o_bp_target       = bp_target_q;

   assign o_init_valid = !w_run;
   assign o_init_index = idx_q;
   assign o_fetch_hold = !w_run;
   assign o_drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_sched.sv
`default_nettype none
// ============================================================================
// tb_bpu_update_sched : directed self-checking bench for bpu_update_sched
// Revision: 1.0
// ============================================================================
module tb_bpu_update_sched;

   logic       clk = 1'b0;
   logic       arst;
   logic       stall;
   logic       init_req;
   logic       init_valid;
   logic       fetch_hold;
   logic [5:0] init_index;
   logic [7:0] drop_cnt;
   int         errors = 0;
   int         checks = 0;

   bpu_update_sched_if #(.ADDR_WIDTH(64)) bus ();

   always #5 clk = ~clk;

   bpu_update_sched #(
      .ADDR_WIDTH (64),
      .FIFO_DEPTH (4),
      .SET_COUNT  (64)
   ) dut (
      .i_clk         (clk),
      .i_arst        (arst),
      .i_stall_fetch (stall),
      .i_init_req    (init_req),
      .bus           (bus.slave),
      .o_init_valid  (init_valid),
      .o_init_index  (init_index),
      .o_fetch_hold  (fetch_hold),
      .o_drop_cnt    (drop_cnt)
   );

   task automatic offer(input logic v, input logic c, input logic t, input logic [1:0] w,
                        input logic [63:0] pc, input logic [63:0] tg);
      bus.i_upd_valid  = v;
      bus.i_upd_cond   = c;
      bus.i_upd_taken  = t;
      bus.i_upd_way    = w;
      bus.i_upd_pc     = pc;
      bus.i_upd_target = tg;
   endtask

   task automatic test_reset;
      arst = 1'b1; stall = 1'b0; init_req = 1'b0;
      offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
      #1 arst = 1'b0;
      #1;
      checks++; if (init_valid !== 1'b1 || fetch_hold !== 1'b1 || init_index !== 6'd0)
         begin errors++; $display("FAIL reset_init: valid=%b hold=%b idx=%0d required 1 1 0", init_valid, fetch_hold, init_index); end
      checks++; if (bus.o_upd_ready !== 1'b0 || drop_cnt !== 8'd0)
         begin errors++; $display("FAIL reset_ready_drop: ready=%b drop=%0d required 0 0", bus.o_upd_ready, drop_cnt); end
      checks++; if (bus.o_bp_branch_instr !== 1'b0 || bus.o_bp_pc_exec !== 64'h0 || bus.o_bp_target !== 64'h0 || bus.o_bp_way !== 2'd0)
         begin errors++; $display("FAIL reset_bp: instr=%b pc=%h required 0 0", bus.o_bp_branch_instr, bus.o_bp_pc_exec); end
      @(negedge clk); @(negedge clk);
      arst = 1'b1;
      for (int k = 0; k < 64; k++) begin
         checks++; if (init_index !== k[5:0] || init_valid !== 1'b1 || fetch_hold !== 1'b1 || bus.o_upd_ready !== 1'b0)
            begin errors++; $display("FAIL sweep_%0d: idx=%0d valid=%b hold=%b ready=%b required %0d 1 1 0", k, init_index, init_valid, fetch_hold, bus.o_upd_ready, k); end
         @(negedge clk);
      end
      checks++; if (bus.o_upd_ready !== 1'b1 || fetch_hold !== 1'b0 || init_valid !== 1'b0)
         begin errors++; $display("FAIL sweep_done: ready=%b hold=%b valid=%b required 1 0 0", bus.o_upd_ready, fetch_hold, init_valid); end
   endtask

   task automatic test_single_push;
      offer(1'b1, 1'b0, 1'b1, 2'd2, 64'h1000, 64'h2000);
      @(negedge clk);
      offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
      checks++; if (bus.o_bp_branch_instr !== 1'b0)
         begin errors++; $display("FAIL single_early: instr=%b required 0", bus.o_bp_branch_instr); end
      @(negedge clk);
      checks++; if (bus.o_bp_branch_instr !== 1'b1 || bus.o_bp_branch_taken !== 1'b1 || bus.o_bp_way !== 2'd2 ||
                    bus.o_bp_pc_exec !== 64'h1000 || bus.o_bp_target !== 64'h2000 || init_valid !== 1'b0)
         begin errors++; $display("FAIL single_issue: instr=%b taken=%b way=%0d pc=%h tgt=%h required 1 1 2 1000 2000",
                                  bus.o_bp_branch_instr, bus.o_bp_branch_taken, bus.o_bp_way, bus.o_bp_pc_exec, bus.o_bp_target); end
      @(negedge clk);
      checks++; if (bus.o_bp_branch_instr !== 1'b0 || bus.o_bp_pc_exec !== 64'h1000)
         begin errors++; $display("FAIL single_once: instr=%b pc=%h required 0 1000", bus.o_bp_branch_instr, bus.o_bp_pc_exec); end
   endtask

   task automatic test_stall_fill;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, 1'b0, 1'b1, i[1:0], 64'h3000 + 64'(16 * i), 64'h4000 + 64'(i));
         @(negedge clk);
      end
      checks++; if (bus.o_upd_ready !== 1'b0)
         begin errors++; $display("FAIL stall_full: ready=%b required 0", bus.o_upd_ready); end
      offer(1'b1, 1'b1, 1'b1, 2'd3, 64'h3fff, 64'h4fff);
      @(negedge clk);
      offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
      checks++; if (drop_cnt !== 8'd1)
         begin errors++; $display("FAIL stall_drop: drop=%0d required 1", drop_cnt); end
      for (int s = 0; s < 5; s++) begin
         checks++; if (bus.o_bp_branch_instr !== 1'b0 || bus.o_bp_pc_exec !== 64'h1000)
            begin errors++; $display("FAIL stall_hold_%0d: instr=%b pc=%h required 0 1000", s, bus.o_bp_branch_instr, bus.o_bp_pc_exec); end
         @(negedge clk);
      end
      stall = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++; if (bus.o_bp_branch_instr !== 1'b1 || bus.o_bp_pc_exec !== 64'h3000 + 64'(16 * j) ||
                       bus.o_bp_target !== 64'h4000 + 64'(j) || bus.o_bp_way !== j[1:0])
            begin errors++; $display("FAIL stall_drain_%0d: instr=%b pc=%h way=%0d required 1 %h %0d",
                                     j, bus.o_bp_branch_instr, bus.o_bp_pc_exec, bus.o_bp_way, 64'h3000 + 64'(16 * j), j); end
      end
      @(negedge clk);
      checks++; if (bus.o_bp_branch_instr !== 1'b0 || bus.o_upd_ready !== 1'b1)
         begin errors++; $display("FAIL stall_empty: instr=%b ready=%b required 0 1", bus.o_bp_branch_instr, bus.o_upd_ready); end
   endtask

   task automatic test_push_pop_wrap;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 1'b0, 1'b1, 2'd1, 64'h5000 + 64'(i), 64'h5100 + 64'(i));
         @(negedge clk);
      end
      checks++; if (bus.o_upd_ready !== 1'b1)
         begin errors++; $display("FAIL wrap_ready3: ready=%b required 1", bus.o_upd_ready); end
      for (int j = 0; j < 6; j++) begin
         stall = 1'b0;
         if (j < 3) offer(1'b1, 1'b0, 1'b1, 2'd1, 64'h5003 + 64'(j), 64'h5103 + 64'(j));
         else       offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
         @(negedge clk);
         checks++; if (bus.o_bp_branch_instr !== 1'b1 || bus.o_bp_pc_exec !== 64'h5000 + 64'(j) || bus.o_bp_target !== 64'h5100 + 64'(j))
            begin errors++; $display("FAIL wrap_order_%0d: instr=%b pc=%h required 1 %h", j, bus.o_bp_branch_instr, bus.o_bp_pc_exec, 64'h5000 + 64'(j)); end
         if (j < 3) begin
            checks++; if (bus.o_upd_ready !== 1'b1)
               begin errors++; $display("FAIL wrap_count_%0d: ready=%b required 1", j, bus.o_upd_ready); end
         end
      end
   endtask

   task automatic test_silent_pop;
      logic        obs_instr [7];
      logic        obs_taken [7];
      logic [63:0] obs_pc    [7];
      int          pulses;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0:       offer(1'b1, 1'b0, 1'b1, 2'd0, 64'h6000, 64'h6100);
            1:       offer(1'b1, 1'b0, 1'b0, 2'd1, 64'h6010, 64'h6110);
            2:       offer(1'b1, 1'b1, 1'b0, 2'd2, 64'h6020, 64'h6120);
            default: offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
         endcase
         @(negedge clk);
         obs_instr[i] = bus.o_bp_branch_instr;
         obs_taken[i] = bus.o_bp_branch_taken;
         obs_pc[i]    = bus.o_bp_pc_exec;
      end
      pulses = 0;
      for (int i = 0; i < 7; i++) pulses += int'(obs_instr[i]);
      checks++; if (pulses != 2)
         begin errors++; $display("FAIL silent_pulses: count=%0d required 2", pulses); end
      checks++; if (obs_instr[1] !== 1'b1 || obs_pc[1] !== 64'h6000)
         begin errors++; $display("FAIL silent_first: instr=%b pc=%h required 1 6000", obs_instr[1], obs_pc[1]); end
      checks++; if (obs_instr[2] !== 1'b0)
         begin errors++; $display("FAIL silent_gap: instr=%b required 0", obs_instr[2]); end
      checks++; if (obs_instr[3] !== 1'b1 || obs_pc[3] !== 64'h6020 || obs_taken[3] !== 1'b0)
         begin errors++; $display("FAIL silent_cond: instr=%b pc=%h taken=%b required 1 6020 0", obs_instr[3], obs_pc[3], obs_taken[3]); end
   endtask

   task automatic test_init_req;
      int pulses;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         offer(1'b1, 1'b0, 1'b1, 2'd3, 64'h8000 + 64'(i), 64'h8100);
         @(negedge clk);
      end
      stall = 1'b0; init_req = 1'b1;
      offer(1'b1, 1'b0, 1'b1, 2'd0, 64'hdead, 64'hbeef);
      @(negedge clk);
      init_req = 1'b0;
      offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
      checks++; if (drop_cnt !== 8'd2 || bus.o_bp_branch_instr !== 1'b0)
         begin errors++; $display("FAIL init_enter: drop=%0d instr=%b required 2 0", drop_cnt, bus.o_bp_branch_instr); end
      checks++; if (init_valid !== 1'b1 || init_index !== 6'd0 || fetch_hold !== 1'b1 || bus.o_upd_ready !== 1'b0)
         begin errors++; $display("FAIL init_state: valid=%b idx=%0d hold=%b ready=%b required 1 0 1 0", init_valid, init_index, fetch_hold, bus.o_upd_ready); end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++; if (init_index !== k[5:0] || bus.o_bp_branch_instr !== 1'b0)
            begin errors++; $display("FAIL init_sweepA_%0d: idx=%0d instr=%b required %0d 0", k, init_index, bus.o_bp_branch_instr, k); end
      end
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      checks++; if (init_index !== 6'd0 || init_valid !== 1'b1)
         begin errors++; $display("FAIL init_restart: idx=%0d valid=%b required 0 1", init_index, init_valid); end
      stall = 1'b1;
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         checks++; if (init_index !== k[5:0] || init_valid !== 1'b1 || bus.o_bp_branch_instr !== 1'b0)
            begin errors++; $display("FAIL init_sweepB_%0d: idx=%0d valid=%b instr=%b required %0d 1 0", k, init_index, init_valid, bus.o_bp_branch_instr, k); end
      end
      @(negedge clk);
      checks++; if (bus.o_upd_ready !== 1'b1 || init_valid !== 1'b0 || fetch_hold !== 1'b0)
         begin errors++; $display("FAIL init_done: ready=%b valid=%b hold=%b required 1 0 0", bus.o_upd_ready, init_valid, fetch_hold); end
      stall = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pulses += int'(bus.o_bp_branch_instr);
      end
      checks++; if (pulses != 0)
         begin errors++; $display("FAIL init_flushed: pulses=%0d required 0", pulses); end
   endtask

   task automatic test_drop_saturate;
      stall = 1'b1;
      offer(1'b1, 1'b0, 1'b1, 2'd3, 64'h7000, 64'h7100);
      repeat (4) @(negedge clk);
      checks++; if (drop_cnt !== 8'd2 || bus.o_upd_ready !== 1'b0)
         begin errors++; $display("FAIL sat_fill: drop=%0d ready=%b required 2 0", drop_cnt, bus.o_upd_ready); end
      repeat (300) @(negedge clk);
      offer(1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
      checks++; if (drop_cnt !== 8'd255)
         begin errors++; $display("FAIL sat_drop: drop=%0d required 255", drop_cnt); end
      stall = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (bus.o_bp_pc_exec !== 64'h7000 || bus.o_bp_way !== 2'd3)
         begin errors++; $display("FAIL sat_drain: pc=%h way=%0d required 7000 3", bus.o_bp_pc_exec, bus.o_bp_way); end
   endtask

   task automatic test_reset_midrun;
      #2 arst = 1'b0;
      #1;
      checks++; if (drop_cnt !== 8'd0 || bus.o_bp_pc_exec !== 64'h0 || bus.o_bp_way !== 2'd0)
         begin errors++; $display("FAIL rearst_regs: drop=%0d pc=%h way=%0d required 0 0 0", drop_cnt, bus.o_bp_pc_exec, bus.o_bp_way); end
      checks++; if (init_valid !== 1'b1 || fetch_hold !== 1'b1 || bus.o_upd_ready !== 1'b0 || init_index !== 6'd0)
         begin errors++; $display("FAIL rearst_state: valid=%b hold=%b ready=%b idx=%0d required 1 1 0 0", init_valid, fetch_hold, bus.o_upd_ready, init_index); end
      @(negedge clk);
      arst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_stall_fill();
      test_push_pop_wrap();
      test_silent_pop();
      test_init_req();
      test_drop_saturate();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
